// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS trace buffer: default depth, entry kinds
// and the 97-bit packed trace entry.
package mips_trace_pkg;

  localparam int TRACE_DEPTH = 8;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo_ram.sv
// Trace entry storage: two write ports at consecutive addresses (waddr and
// waddr+1) and one asynchronous read port.
module trace_fifo_ram
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic [AW-1:0] waddr,
  input  logic          we0,
  input  trace_entry_t  wdata0,
  input  logic          we1,
  input  trace_entry_t  wdata1,
  input  logic [AW-1:0] raddr,
  output trace_entry_t  rdata
);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] waddr1;

  // Wraps naturally because DEPTH is a power of two.
  assign waddr1 = waddr + AW'(1);

  // NOTE: storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr]  <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_trace_buf.sv
// Trace buffer capturing GRF and DM write events from a MIPS CPU into a FIFO,
// with GRF-first priority, drop accounting and a valid/ready drain stream.
module mips_trace_buf
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grf_we,
  input  logic [31:0] grf_pc,
  input  logic [4:0]  grf_addr,
  input  logic [31:0] grf_wdata,
  input  logic        dm_we,
  input  logic [31:0] dm_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_kind,
  output logic [31:0] out_pc,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        almost_full,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic [CW:0]   free_slots;
  logic          acc_grf, acc_dm;
  logic [1:0]    n_push, n_drop;
  logic [8:0]    drop_sum;
  trace_entry_t  grf_entry, dm_entry, wr_entry0, head;

  assign grf_entry = '{kind: KIND_GRF, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wdata};
  assign dm_entry  = '{kind: KIND_DM,  pc: dm_pc,  addr: dm_addr,           data: dm_wdata};

  assign out_valid   = (count != '0);
  assign almost_full = (count >= CW'(DEPTH - 1));
  assign pop         = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free_slots = '0;
    acc_grf    = 1'b0;
    acc_dm     = 1'b0;
    n_push     = '0;
    n_drop     = '0;
    wr_entry0  = dm_entry;
    drop_sum   = '0;

    // A pop this cycle frees its slot for a same-cycle push.
    free_slots = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
    acc_grf    = grf_we && (free_slots != '0);
    acc_dm     = dm_we && (free_slots > (acc_grf ? (CW+1)'(1) : (CW+1)'(0)));
    n_push     = {1'b0, acc_grf} + {1'b0, acc_dm};
    n_drop     = {1'b0, grf_we & ~acc_grf} + {1'b0, dm_we & ~acc_dm};
    if (acc_grf) wr_entry0 = grf_entry;
    drop_sum   = {1'b0, drop_cnt} + {7'b0, n_drop};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(n_push);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + CW'(n_push) - CW'(pop);
      if (n_drop != '0) overflow <= 1'b1;
      drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

  trace_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .waddr  (wr_ptr),
    .we0    ((acc_grf | acc_dm) & reset),
    .wdata0 (wr_entry0),
    .we1    (acc_grf & acc_dm & reset),
    .wdata1 (dm_entry),
    .raddr  (rd_ptr),
    .rdata  (head)
  );

  assign out_kind = head.kind;
  assign out_pc   = head.pc;
  assign out_addr = head.addr;
  assign out_data = head.data;

endmodule

// File: tb/tb_mips_trace_buf.sv
// Scoreboard bench for mips_trace_buf: directed scenarios plus randomized
// traffic, checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_mips_trace_buf;
  import mips_trace_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wdata;
  logic        dm_we;
  logic [31:0] dm_pc, dm_addr, dm_wdata;
  logic        out_valid, out_ready, out_kind;
  logic [31:0] out_pc, out_addr, out_data;
  logic        almost_full, overflow;
  logic [7:0]  drop_cnt;

  mips_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .almost_full(almost_full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state for the current cycle.
  trace_entry_t exp_q[$];
  int           cur_cnt  = 0;
  int           cur_drop = 0;
  bit           cur_ovf  = 1'b0;
  bit           mon_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic trace_entry_t mk(input bit kind, input logic [31:0] pc,
                                      input logic [31:0] addr, input logic [31:0] data);
    trace_entry_t e;
    e.kind = kind; e.pc = pc; e.addr = addr; e.data = data;
    return e;
  endfunction

  function automatic trace_entry_t rand_grf();
    return mk(KIND_GRF, $urandom, {27'b0, 5'($urandom)}, $urandom);
  endfunction

  function automatic trace_entry_t rand_dm();
    return mk(KIND_DM, $urandom, $urandom, $urandom);
  endfunction

  // Apply one cycle of stimulus and advance the model across the next edge.
  task automatic step(input bit g, input trace_entry_t ge, input bit d,
                      input trace_entry_t de, input bit r);
    int free;
    int drops;
    grf_we = g; grf_pc = ge.pc; grf_addr = ge.addr[4:0]; grf_wdata = ge.data;
    dm_we  = d; dm_pc  = de.pc; dm_addr  = de.addr;      dm_wdata  = de.data;
    out_ready = r;
    free  = DEPTH - cur_cnt + ((cur_cnt > 0 && r) ? 1 : 0);
    drops = 0;
    if (g) begin
      if (free > 0) begin exp_q.push_back(ge); free--; end else drops++;
    end
    if (d) begin
      if (free > 0) begin exp_q.push_back(de); free--; end else drops++;
    end
    @(posedge clk);
    #1;
    cur_cnt  = DEPTH - free;
    cur_drop = (cur_drop + drops > 255) ? 255 : cur_drop + drops;
    if (drops > 0) cur_ovf = 1'b1;
  endtask

  task automatic idle(input bit r);
    step(1'b0, rand_grf(), 1'b0, rand_dm(), r);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && cur_cnt > 0; i++) idle(1'b1);
    check("drain_scoreboard_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor: compares flags every cycle and pops the scoreboard on handshakes.
  initial begin
    trace_entry_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("out_valid", 128'(out_valid), 128'(cur_cnt > 0));
        check("almost_full", 128'(almost_full), 128'(cur_cnt >= DEPTH - 1));
        check("overflow", 128'(overflow), 128'(cur_ovf));
        check("drop_cnt", 128'(drop_cnt), 128'(cur_drop));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pop act=valid exp=empty at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("entry", 128'({out_kind, out_pc, out_addr, out_data}), 128'(e));
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    trace_entry_t g0, d0;
    reset = 1'b0;
    grf_we = 0; grf_pc = 0; grf_addr = 0; grf_wdata = 0;
    dm_we = 0; dm_pc = 0; dm_addr = 0; dm_wdata = 0; out_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_almost_full", 128'(almost_full), 128'd0);
    check("rst_overflow", 128'(overflow), 128'd0);
    check("rst_drop_cnt", 128'(drop_cnt), 128'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Single GRF write, drained immediately.
    g0 = mk(KIND_GRF, 32'h0000_3000, 32'h8, 32'h1234_5678);
    step(1'b1, g0, 1'b0, rand_dm(), 1'b1);
    check("single_out_addr", 128'(out_addr), 128'h8);
    check("single_out_kind", 128'(out_kind), 128'(KIND_GRF));
    idle(1'b1);
    idle(1'b1);
    check("single_empty_after", 128'(out_valid), 128'd0);

    // Simultaneous GRF and DM events: GRF first, then DM.
    g0 = mk(KIND_GRF, 32'h0000_3004, 32'h3, 32'h5555_0001);
    d0 = mk(KIND_DM,  32'h0000_3004, 32'h10, 32'h0000_ABCD);
    step(1'b1, g0, 1'b1, d0, 1'b0);
    idle(1'b0);
    check("dual_head_kind", 128'(out_kind), 128'(KIND_GRF));
    drain();

    // Nine GRF writes into a depth-8 FIFO with the drain stalled.
    for (int i = 0; i < 9; i++)
      step(1'b1, mk(KIND_GRF, 32'h4000 + 32'(4 * i), 32'(i), 32'(i * 7)), 1'b0, rand_dm(), 1'b0);
    check("fill_overflow", 128'(overflow), 128'd1);
    check("fill_drop_cnt", 128'(drop_cnt), 128'd1);

    // Full FIFO, push with a simultaneous pop: nothing dropped.
    step(1'b1, rand_grf(), 1'b0, rand_dm(), 1'b1);
    check("full_pushpop_drop_cnt", 128'(drop_cnt), 128'd1);
    check("full_pushpop_almost_full", 128'(almost_full), 128'd1);

    // 300 dropped events saturate the counter.
    for (int i = 0; i < 150; i++) step(1'b1, rand_grf(), 1'b1, rand_dm(), 1'b0);
    check("sat_drop_cnt", 128'(drop_cnt), 128'd255);
    check("sat_overflow", 128'(overflow), 128'd1);

    // Drain down to 5 entries, then reset asynchronously between edges.
    repeat (3) idle(1'b1);
    out_ready = 1'b0;
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", 128'(out_valid), 128'd0);
    check("async_rst_overflow", 128'(overflow), 128'd0);
    check("async_rst_drop_cnt", 128'(drop_cnt), 128'd0);
    exp_q.delete();
    cur_cnt = 0; cur_drop = 0; cur_ovf = 1'b0;
    grf_we = 1'b1; dm_we = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_ignores_inputs", 128'(out_valid), 128'd0);
    grf_we = 1'b0; dm_we = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    step(1'b1, rand_grf(), 1'b0, rand_dm(), 1'b0);
    idle(1'b1);
    check("post_rst_single_entry", 128'(out_valid), 128'd0);
    drain();

    // Randomized traffic with alternating drain pressure.
    for (int ph = 0; ph < 20; ph++) begin
      int bias = (ph % 2 == 0) ? 1 : 3;
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 2) != 0, rand_grf(), $urandom_range(0, 2) == 0, rand_dm(),
             $urandom_range(0, 3) < bias);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
